button_conditioner: RTL
=======================

# button_conditioner

Input-conditioning stage between the board's raw push-buttons/switches and the multiplier control logic. It synchronizes asynchronous active-low key inputs into the `Clk` domain and debounces them. It produces clean active-high levels plus single-cycle press/release pulses; the multiplier's `Run` and `Reset_Load_Clear` controls are driven from its outputs. It optionally synchronizes the 8-bit operand switches.

## Interface
Parameters:
- `NUM_BTN`, 2: number of key channels; channel 0 is `Reset_Load_Clear`, channel 1 is `Run`.
- `SYNC_STAGES`, 2: synchronizer flop depth; legal range 2..4.
- `DEBOUNCE_CYCLES`, 500000: consecutive cycles a new value must hold before it is accepted (10 ms at 50 MHz); minimum 2.

Ports:
- `Clk` in 1: system clock, 50 MHz.
- `Reset` in 1: synchronous, active-high reset; one clock; all state resets on the rising `Clk` edge while `Reset`=1.
- `Btn_n` in NUM_BTN: raw keys, active-low, asynchronous.
- `SW_raw` in 8: raw operand switches, asynchronous.
- `Btn_level` out NUM_BTN: debounced state, 1 = pressed.
- `Btn_press` out NUM_BTN: one-cycle pulse on an accepted press.
- `Btn_release` out NUM_BTN: one-cycle pulse on an accepted release.
- `SW_sync` out 8: operand switches delivered to the datapath.

## Operation
- Each channel has the following chain: `SYNC_STAGES`-deep flop chain → debounce counter → stable register → edge detect.
- Synchronizer flops reset to 1, which is the released state of an active-low key.
- Debounce logic, per cycle, uses `s` = synchronized input inverted (1 = pressed) and `L` = stable level:
  - If `s == L`: counter ← 0.
  - If `s != L` and counter < DEBOUNCE_CYCLES-1: counter ← counter+1.
  - If `s != L` and counter == DEBOUNCE_CYCLES-1: `L` ← `s` and counter ← 0.
- Counter width is `$clog2(DEBOUNCE_CYCLES)`. The counter never wraps, and it saturates only by the flip rule above.
- A bounce that lasts fewer than DEBOUNCE_CYCLES cycles clears the counter and leaves `L` unchanged.
- `Btn_press` = `L` rising, registered. `Btn_release` = `L` falling, registered. Both are asserted in the same cycle that `Btn_level` changes and last exactly one cycle.
- Channels are fully independent. Simultaneous events on several channels each produce their own pulses in the same cycle.
- Reset values: `Btn_level`=0, `Btn_press`=0, `Btn_release`=0, all counters 0, `SW_sync`=0.
- Reset mid-debounce: the pending count is discarded.
- A key held through reset is treated as a new press after reset deasserts. It produces exactly one `Btn_press` after the full latency.

## Timing
- Press latency: a raw low held stable from edge k causes `Btn_level`=1 and `Btn_press`=1 at edge k+SYNC_STAGES+DEBOUNCE_CYCLES.
- Release latency is identical.
- `Btn_press` is deasserted on the following edge.
- Minimum accepted pulse width on `Btn_n` is DEBOUNCE_CYCLES cycles.
- `SW_sync` latency is SYNC_STAGES cycles when synchronization is enabled, and 0 cycles otherwise.
- No combinational path exists from any input to any output, except `SW_sync` when `BTN_COND_SW_SYNC_EN` is undefined.

## Configuration
- Macro `BTN_COND_SW_SYNC_EN`.
- Defined: `SW_raw` passes through a `SYNC_STAGES`-deep flop chain that resets to 0.
- Undefined: `SW_sync` = `SW_raw` combinationally. The reset value of `SW_sync` then follows the input.
- The synthesis build defines the macro. Simulation benches test both settings.

## Structure
- Package `btn_cond_pkg` holds:
  - `BTN_RLC`=0 and `BTN_RUN`=1 channel index constants.
  - Default `SYNC_STAGES`/`DEBOUNCE_CYCLES`.
  - `SIM_DEBOUNCE_CYCLES`=4.
- Sub-module `debounce_channel` holds one synchronizer, counter, stable register and edge detector. The top level generates `NUM_BTN` instances plus the switch synchronizer.

## Test plan
All scenarios use SYNC_STAGES=2 and DEBOUNCE_CYCLES=4.
- Clean press: `Btn_n[1]` 1→0 at edge 10 and held → `Btn_level[1]`=1 and `Btn_press[1]`=1 at edge 16, `Btn_press[1]`=0 at edge 17, no `Btn_release`.
- Bounce rejection: `Btn_n[0]` low for 3 cycles, then high → `Btn_level[0]` stays 0, and no pulses.
- Release: from pressed, `Btn_n[1]` 0→1 held → `Btn_level[1]`=0 and a one-cycle `Btn_release[1]` 6 cycles later.
- Reset mid-count: `Btn_n[0]` low, then `Reset`=1 for 1 cycle at count 2, key still held → all outputs 0 during reset, then `Btn_press[0]` 6 cycles after reset deasserts.
- Simultaneous: both keys pressed on the same edge → `Btn_press`=2'b11 for exactly one cycle.
- Switches: with the macro defined, `SW_raw`=8'hC5 → `SW_sync`=8'hC5 two edges later, and `SW_sync`=0 during `Reset`. Without the macro, `SW_sync` follows immediately.

Source files
------------

// File: rtl/btn_cond_pkg.sv
// Shared channel indices and default timing for the key conditioner.
// Pure constants; no logic, latency or flow control.
package btn_cond_pkg;

    localparam int BTN_RLC = 0;
    localparam int BTN_RUN = 1;

    localparam int DEF_SYNC_STAGES     = 2;
    localparam int DEF_DEBOUNCE_CYCLES = 500000;
    localparam int SIM_DEBOUNCE_CYCLES = 4;

endpackage

// File: rtl/debounce_channel.sv
// One key: synchronizer, debounce counter, stable level and press/release pulse registers.
// Latency SYNC_STAGES+DEBOUNCE_CYCLES cycles from raw edge to level/pulse; no backpressure.
module debounce_channel
    import btn_cond_pkg::*;
#(
    parameter int SYNC_STAGES     = DEF_SYNC_STAGES,
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
    input  logic clk,
    input  logic reset,
    input  logic key_n,
    output logic level,
    output logic press_pulse,
    output logic release_pulse
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic [SYNC_STAGES-1:0] sync;
    logic [CW-1:0]          count;
    logic                   pressed;

    // Synchronizer resets to all-ones so a key held through reset reads as a fresh press.
    assign pressed = ~sync[SYNC_STAGES-1];

    always_ff @(posedge clk) begin
        if (reset) begin
            sync          <= '1;
            count         <= '0;
            level         <= 1'b0;
            press_pulse   <= 1'b0;
            release_pulse <= 1'b0;
        end else begin
            sync          <= {sync[SYNC_STAGES-2:0], key_n};
            press_pulse   <= 1'b0;
            release_pulse <= 1'b0;
            if (pressed == level) begin
                count <= '0;
            end else if (count != CNT_LAST) begin
                count <= count + 1'b1;
            end else begin
                count         <= '0;
                level         <= pressed;
                press_pulse   <= pressed;
                release_pulse <= ~pressed;
            end
        end
    end

endmodule

// File: rtl/button_conditioner.sv
// Debounces NUM_BTN active-low keys into levels and one-cycle press/release pulses (SYNC_STAGES+DEBOUNCE_CYCLES latency, no backpressure).
// SW_sync goes through a SYNC_STAGES flop chain when BTN_COND_SW_SYNC_EN is defined, otherwise it is a direct wire.
module button_conditioner
    import btn_cond_pkg::*;
#(
    parameter int NUM_BTN         = 2,
    parameter int SYNC_STAGES     = DEF_SYNC_STAGES,
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
    input  logic               Clk,
    input  logic               Reset,
    input  logic [NUM_BTN-1:0] Btn_n,
    input  logic [7:0]         SW_raw,
    output logic [NUM_BTN-1:0] Btn_level,
    output logic [NUM_BTN-1:0] Btn_press,
    output logic [NUM_BTN-1:0] Btn_release,
    output logic [7:0]         SW_sync
);

    if (SYNC_STAGES < 2 || SYNC_STAGES > 4 || DEBOUNCE_CYCLES < 2) begin : g_bad_params
        $error("button_conditioner: SYNC_STAGES must be 2..4 and DEBOUNCE_CYCLES at least 2");
    end

    for (genvar i = 0; i < NUM_BTN; i++) begin : g_btn
        debounce_channel #(
            .SYNC_STAGES    (SYNC_STAGES),
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_chan (
            .clk          (Clk),
            .reset        (Reset),
            .key_n        (Btn_n[i]),
            .level        (Btn_level[i]),
            .press_pulse  (Btn_press[i]),
            .release_pulse(Btn_release[i])
        );
    end

`ifdef BTN_COND_SW_SYNC_EN
    logic [7:0] sw_chain [SYNC_STAGES];

    always_ff @(posedge Clk) begin
        if (Reset) begin
            for (int i = 0; i < SYNC_STAGES; i++) sw_chain[i] <= '0;
        end else begin
            sw_chain[0] <= SW_raw;
            for (int i = 1; i < SYNC_STAGES; i++) sw_chain[i] <= sw_chain[i-1];
        end
    end

    assign SW_sync = sw_chain[SYNC_STAGES-1];
`else
    assign SW_sync = SW_raw;
`endif

endmodule
